imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter IMEM_DEPTH, default 256: number of 32-bit IMEM words.
REQ-002 Parameter AW, default 8: word-address width, clog2(IMEM_DEPTH).
REQ-003 clk  input  1  system clock, rising-edge.
REQ-004 rst  input  1  reset; one clock, asynchronous, active-high.
REQ-005 load_start  input  1  single-cycle pulse; begins a new program load.
REQ-006 in_valid  input  1  program byte valid.
REQ-007 in_data  input  8  program byte, little-endian stream order.
REQ-008 in_last  input  1  qualifies the final byte of the program.
REQ-009 in_ready  output  1  loader accepts a byte this cycle.
REQ-010 imem_we  output  1  one-cycle IMEM word-write strobe.
REQ-011 imem_waddr  output  AW  IMEM word index.
REQ-012 imem_wdata  output  32  write data; [7:0] to lane b0 ... [31:24] to lane b3.
REQ-013 cpu_rst  output  1  holds the CPU in reset while asserted.
REQ-014 done  output  1  load completed successfully.
REQ-015 err  output  1  program overflowed IMEM_DEPTH.
REQ-016 words_loaded  output  AW+1  count of words written.

Function
REQ-017 A byte shall be accepted only on a cycle where in_valid and in_ready are both high.
REQ-018 FSM states: IDLE, LOAD, FLUSH, DONE, ERROR.
REQ-019 IDLE: in_ready=0; cpu_rst=1; load_start moves the FSM to LOAD and clears the byte lane, address and words_loaded.
REQ-020 LOAD: in_ready=1; each accepted byte fills lane 0,1,2,3 in order, tracked by a 2-bit lane counter.
REQ-021 When the lane-3 byte is accepted, imem_we shall pulse on the next cycle with the assembled word at the current address; the address and words_loaded then increment.
REQ-022 When in_last is accepted on lane 3, the FSM shall go to DONE after that write.
REQ-023 When in_last is accepted on lane 0-2, the FSM shall enter FLUSH; the unfilled upper lanes shall be written as 0x00 in the write cycle.
REQ-024 The FSM shall go to DONE after the FLUSH write; in_ready=0 in FLUSH.
REQ-025 Accepting a byte while the address equals IMEM_DEPTH shall cause the following:
  - go to ERROR;
  - no write is issued;
  - err=1 and in_ready=0.
REQ-026 ERROR holds cpu_rst=1 and err=1 until load_start, which restarts LOAD.
REQ-027 DONE: done=1 and in_ready=0; cpu_rst deasserts on the cycle after the final imem_we pulse.
REQ-028 In DONE, load_start shall reassert cpu_rst on the next cycle, clear done, and re-enter LOAD.
REQ-029 load_start in LOAD or FLUSH shall be ignored.
REQ-030 imem_waddr and imem_wdata shall be registered and held stable between writes.

Reset
REQ-031 On rst, all outputs shall take these values:
  - FSM=IDLE and cpu_rst=1;
  - in_ready, imem_we, done and err = 0;
  - imem_waddr, imem_wdata, words_loaded and the lane counter = 0.
REQ-032 rst asserted mid-load shall abort the load immediately with no further imem_we.

Structure
REQ-033 A shared package shall hold the FSM state enum and the IMEM_DEPTH default constant.
REQ-034 One sub-module, imem_word_pack, shall perform the byte-to-word assembly and lane counting.

Verification
REQ-035 24-byte stream of the six-instruction add/sw/lw/sub program -> the following results:
  - six writes, addresses 0-5, first 0x00A00093, last 0x401202B3;
  - cpu_rst falls;
  - after 6 CPU cycles, x3=30, x4=30, x5=20.
REQ-036 6 bytes AA BB CC DD EE FF with in_last on FF -> word0=0xDDCCBBAA and word1=0x0000FFEE (written from FLUSH); words_loaded=2; done=1.
REQ-037 in_valid toggled randomly with gaps -> identical writes; one imem_we per 4 accepted bytes; no write issued mid-word.
REQ-038 IMEM_DEPTH=4 with 20 bytes -> 4 writes then err=1, in_ready=0, cpu_rst=1; load_start followed by 8 bytes -> done=1, err=0.
REQ-039 rst pulsed after 10 bytes -> no further writes; IDLE reached; cpu_rst=1; words_loaded=0.
REQ-040 load_start pulsed in DONE -> the following results:
  - cpu_rst rises next cycle;
  - a reload starts at address 0;
  - the new words overwrite the old ones.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared FSM state type and IMEM sizing defaults for the IMEM loader
package imem_loader_pkg;

    localparam int IMEM_DEPTH_DEFAULT = 256;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FLUSH,
        ST_DONE,
        ST_ERROR
    } state_e;

endpackage

// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - program byte stream in, IMEM word-write port out
// Ports: in_valid/in_data/in_last/in_ready byte stream; imem_we/imem_waddr/imem_wdata word write.
interface imem_loader_if #(
    parameter int AW = 8
);
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_last;
    logic          in_ready;
    logic          imem_we;
    logic [AW-1:0] imem_waddr;
    logic [31:0]   imem_wdata;

    modport master (
        output in_valid, in_data, in_last,
        input  in_ready, imem_we, imem_waddr, imem_wdata
    );

    modport slave (
        input  in_valid, in_data, in_last,
        output in_ready, imem_we, imem_waddr, imem_wdata
    );
endinterface

// File: rtl/imem_word_pack.sv
// rtl/imem_word_pack.sv - little-endian byte-to-word assembly with a 2-bit lane counter
// Ports: clear restarts at lane 0; accept consumes in_data into the current lane;
//        lane is the lane the next byte lands in; word is the word including in_data.
module imem_word_pack (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        accept,
    input  logic [7:0]  in_data,
    output logic [1:0]  lane,
    output logic [31:0] word
);
    logic [1:0]  lane_q, lane_d;
    logic [23:0] low_q, low_d;

    always_comb begin
        lane_d = lane_q;
        low_d  = low_q;
        if (clear) begin
            lane_d = 2'd0;
            low_d  = 24'h0;
        end else if (accept) begin
            case (lane_q)
                2'd0:    low_d[7:0]   = in_data;
                2'd1:    low_d[15:8]  = in_data;
                2'd2:    low_d[23:16] = in_data;
                default: ;
            endcase
            lane_d = lane_q + 2'd1;
        end
    end

    // Lanes above the incoming byte are forced to zero, so a short final
    // word never carries stale bytes from the previous word.
    always_comb begin
        case (lane_q)
            2'd0:    word = {24'h0, in_data};
            2'd1:    word = {16'h0, in_data, low_q[7:0]};
            2'd2:    word = {8'h0, in_data, low_q[15:0]};
            default: word = {in_data, low_q};
        endcase
    end

    assign lane = lane_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane_q <= 2'd0;
            low_q  <= 24'h0;
        end else begin
            lane_q <= lane_d;
            low_q  <= low_d;
        end
    end
endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - streams program bytes into IMEM words and releases the CPU when done
// Ports: clk, rst (async, active-high); load_start pulse; bus (slave) byte stream + IMEM write;
//        cpu_rst, done, err status; words_loaded count of written words.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int IMEM_DEPTH = IMEM_DEPTH_DEFAULT,
    parameter int AW         = $clog2(IMEM_DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_start,
    imem_loader_if.slave  bus,
    output logic          cpu_rst,
    output logic          done,
    output logic          err,
    output logic [AW:0]   words_loaded
);
    localparam logic [AW:0] DEPTH_W = (AW+1)'(IMEM_DEPTH);
    localparam logic [AW:0] ONE_W   = (AW+1)'(1);

    state_e        state_q, state_d;
    logic          in_ready_q, in_ready_d;
    logic          we_q, we_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          cpu_rst_q, cpu_rst_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [AW:0]   count_q, count_d;
    // Set when the final byte completed a full word: LOAD spends the write
    // cycle with in_ready low, then moves to DONE.
    logic          fin_q, fin_d;

    logic          accept;
    logic          restart;
    logic          full;
    logic [1:0]    lane;
    logic [31:0]   word;

    assign accept  = bus.in_valid && in_ready_q;
    assign full    = (count_q == DEPTH_W);
    assign restart = load_start &&
                     (state_q == ST_IDLE || state_q == ST_DONE || state_q == ST_ERROR);

    imem_word_pack u_pack (
        .clk     (clk),
        .rst     (rst),
        .clear   (restart),
        .accept  (accept && !full),
        .in_data (bus.in_data),
        .lane    (lane),
        .word    (word)
    );

    always_comb begin
        state_d    = state_q;
        in_ready_d = in_ready_q;
        we_d       = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        cpu_rst_d  = cpu_rst_q;
        done_d     = done_q;
        err_d      = err_q;
        count_d    = count_q;
        fin_d      = fin_q;

        if (restart) begin
            state_d    = ST_LOAD;
            in_ready_d = 1'b1;
            waddr_d    = '0;
            count_d    = '0;
            cpu_rst_d  = 1'b1;
            done_d     = 1'b0;
            err_d      = 1'b0;
            fin_d      = 1'b0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (fin_q) begin
                        state_d   = ST_DONE;
                        fin_d     = 1'b0;
                        cpu_rst_d = 1'b0;
                        done_d    = 1'b1;
                    end else if (accept) begin
                        if (full) begin
                            state_d    = ST_ERROR;
                            in_ready_d = 1'b0;
                            err_d      = 1'b1;
                        end else if (lane == 2'd3 || bus.in_last) begin
                            we_d    = 1'b1;
                            waddr_d = count_q[AW-1:0];
                            wdata_d = word;
                            count_d = count_q + ONE_W;
                            if (bus.in_last) begin
                                in_ready_d = 1'b0;
                                if (lane == 2'd3) begin
                                    fin_d = 1'b1;
                                end else begin
                                    state_d = ST_FLUSH;
                                end
                            end
                        end
                    end
                end
                ST_FLUSH: begin
                    state_d   = ST_DONE;
                    cpu_rst_d = 1'b0;
                    done_d    = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            in_ready_q <= 1'b0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= 32'h0;
            cpu_rst_q  <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            count_q    <= '0;
            fin_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            cpu_rst_q  <= cpu_rst_d;
            done_q     <= done_d;
            err_q      <= err_d;
            count_q    <= count_d;
            fin_q      <= fin_d;
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.imem_we    = we_q;
    assign bus.imem_waddr = waddr_q;
    assign bus.imem_wdata = wdata_q;
    assign cpu_rst        = cpu_rst_q;
    assign done           = done_q;
    assign err            = err_q;
    assign words_loaded   = count_q;
endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed vector bench for imem_loader
module tb_imem_loader;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, ls0, ls4, v, l, rdy;
    logic [7:0] d;
    int         sel;
    logic       cpu_rst0, done0, err0, cpu_rst4, done4, err4;
    logic [8:0] wl0;
    logic [2:0] wl4;

    imem_loader_if #(.AW(8)) bus0 ();
    imem_loader_if #(.AW(2)) bus4 ();

    assign bus0.in_valid = v && (sel == 0);
    assign bus0.in_data  = d;
    assign bus0.in_last  = l;
    assign bus4.in_valid = v && (sel == 1);
    assign bus4.in_data  = d;
    assign bus4.in_last  = l;
    assign rdy = (sel == 0) ? bus0.in_ready : bus4.in_ready;

    imem_loader #(.IMEM_DEPTH(256), .AW(8)) u_dut0 (
        .clk(clk), .rst(rst), .load_start(ls0), .bus(bus0),
        .cpu_rst(cpu_rst0), .done(done0), .err(err0), .words_loaded(wl0)
    );

    imem_loader #(.IMEM_DEPTH(4), .AW(2)) u_dut4 (
        .clk(clk), .rst(rst), .load_start(ls4), .bus(bus4),
        .cpu_rst(cpu_rst4), .done(done4), .err(err4), .words_loaded(wl4)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    logic [7:0]  stream [32];
    int          n_cur, acc_cnt;
    bit          chk_mid = 1'b0;
    int          wr0 = 0, wr4 = 0;
    logic [31:0] wdat0 [64];
    logic [7:0]  wadr0 [64];
    logic [31:0] mem0  [256];
    logic [31:0] wdat4 [8];
    logic [1:0]  wadr4 [8];

    // Write capture, sampled 2 ns after each rising edge.
    always @(posedge clk) begin
        #2;
        if (bus0.imem_we) begin
            if (wr0 < 64) begin
                wdat0[wr0] = bus0.imem_wdata;
                wadr0[wr0] = bus0.imem_waddr;
            end
            mem0[bus0.imem_waddr] = bus0.imem_wdata;
            if (chk_mid)
                chk("bytes_before_write", acc_cnt, (4*(wr0+1) < n_cur) ? 4*(wr0+1) : n_cur);
            wr0++;
        end
        if (bus4.imem_we) begin
            if (wr4 < 8) begin
                wdat4[wr4] = bus4.imem_wdata;
                wadr4[wr4] = bus4.imem_waddr;
            end
            wr4++;
        end
    end

    // Called right after a falling edge; returns on the falling edge after the last acceptance.
    task automatic send(input int first, input int n, input bit use_last, input bit use_gaps);
        int i = first;
        int guard = 0;
        while (i < n && guard < 400) begin
            v = use_gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            d = stream[i];
            l = use_last && (i == n - 1);
            if (v && rdy) begin
                i++;
                acc_cnt++;
            end
            @(negedge clk);
            guard++;
        end
        v = 1'b0;
        l = 1'b0;
        if (i < n) chk("send_timeout", i, n);
    endtask

    task automatic start_load(input int which);
        sel = which;
        if (which == 0) ls0 = 1'b1; else ls4 = 1'b1;
        @(negedge clk);
        ls0 = 1'b0;
        ls4 = 1'b0;
        acc_cnt = 0;
        wr0 = 0;
        wr4 = 0;
    endtask

    typedef struct {
        logic [23:0][7:0] b;
        int               n;
        logic [5:0][31:0] w;
        int               nw;
        bit               gaps;
    } vec_t;

    vec_t        vt [5];
    logic [31:0] prog [6];
    logic        prev_we, prev_cr;
    int          k;

    initial begin
        prog[0] = 32'h00A00093;   // addi x1, x0, 10
        prog[1] = 32'h01400113;   // addi x2, x0, 20
        prog[2] = 32'h002081B3;   // add  x3, x1, x2
        prog[3] = 32'h00302023;   // sw   x3, 0(x0)
        prog[4] = 32'h00002203;   // lw   x4, 0(x0)
        prog[5] = 32'h401202B3;   // sub  x5, x4, x1
        for (int r = 0; r < 5; r++) begin
            vt[r].b = '0; vt[r].w = '0; vt[r].gaps = 1'b0;
        end
        for (int i = 0; i < 24; i++) vt[0].b[i] = prog[i/4][8*(i%4) +: 8];
        vt[0].n = 24; vt[0].nw = 6;
        vt[0].w[0] = 32'h00A00093; vt[0].w[1] = 32'h01400113; vt[0].w[2] = 32'h002081B3;
        vt[0].w[3] = 32'h00302023; vt[0].w[4] = 32'h00002203; vt[0].w[5] = 32'h401202B3;
        vt[1].b[0] = 8'hAA; vt[1].b[1] = 8'hBB; vt[1].b[2] = 8'hCC;
        vt[1].b[3] = 8'hDD; vt[1].b[4] = 8'hEE; vt[1].b[5] = 8'hFF;
        vt[1].n = 6; vt[1].nw = 2; vt[1].w[0] = 32'hDDCCBBAA; vt[1].w[1] = 32'h0000FFEE;
        vt[2] = vt[0]; vt[2].gaps = 1'b1;
        vt[3].b[0] = 8'h5A; vt[3].n = 1; vt[3].nw = 1; vt[3].w[0] = 32'h0000005A;
        for (int i = 0; i < 7; i++) vt[4].b[i] = 8'(i + 1);
        vt[4].n = 7; vt[4].nw = 2; vt[4].w[0] = 32'h04030201; vt[4].w[1] = 32'h00070605;

        rst = 1'b1; ls0 = 1'b0; ls4 = 1'b0; v = 1'b0; l = 1'b0; d = 8'h00; sel = 0;
        acc_cnt = 0; n_cur = 0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", bus0.in_ready, 0);
        chk("rst_we", bus0.imem_we, 0);
        chk("rst_waddr", bus0.imem_waddr, 0);
        chk("rst_wdata", bus0.imem_wdata, 0);
        chk("rst_cpu_rst", cpu_rst0, 1);
        chk("rst_done", done0, 0);
        chk("rst_err", err0, 0);
        chk("rst_words", wl0, 0);
        rst = 1'b0;
        v = 1'b1;
        repeat (3) @(negedge clk);
        v = 1'b0;
        chk("idle_no_accept_ready", bus0.in_ready, 0);
        chk("idle_no_write", wr0, 0);

        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < 24; i++) stream[i] = vt[r].b[i];
            n_cur = vt[r].n;
            start_load(0);
            chk("start_cpu_rst", cpu_rst0, 1);
            chk("start_done_clr", done0, 0);
            chk("start_words_clr", wl0, 0);
            chk_mid = 1'b1;
            send(0, vt[r].n, 1'b1, vt[r].gaps);
            prev_we = 1'b0; prev_cr = 1'b0; k = 0;
            while (!done0 && k < 20) begin
                prev_we = bus0.imem_we;
                prev_cr = cpu_rst0;
                @(negedge clk);
                k++;
            end
            chk_mid = 1'b0;
            chk("done", done0, 1);
            chk("we_before_done", prev_we, 1);
            chk("cpu_rst_during_write", prev_cr, 1);
            chk("cpu_rst_released", cpu_rst0, 0);
            chk("done_in_ready", bus0.in_ready, 0);
            chk("n_writes", wr0, vt[r].nw);
            chk("words_loaded", wl0, vt[r].nw);
            chk("no_err", err0, 0);
            for (int j = 0; j < vt[r].nw; j++) begin
                chk("waddr", wadr0[j], j);
                chk("wdata", wdat0[j], vt[r].w[j]);
            end
            if (r == 0) begin : iss
                logic [31:0] xr [32];
                logic [31:0] dmem [4];
                logic [31:0] ins, immi, imms, ea;
                for (int q = 0; q < 32; q++) xr[q] = 32'h0;
                for (int q = 0; q < 4; q++) dmem[q] = 32'h0;
                for (int pc = 0; pc < 6; pc++) begin
                    ins  = wdat0[pc];
                    immi = {{20{ins[31]}}, ins[31:20]};
                    imms = {{20{ins[31]}}, ins[31:25], ins[11:7]};
                    case (ins[6:0])
                        7'h13: xr[ins[11:7]] = xr[ins[19:15]] + immi;
                        7'h33: xr[ins[11:7]] = ins[30] ? xr[ins[19:15]] - xr[ins[24:20]]
                                                       : xr[ins[19:15]] + xr[ins[24:20]];
                        7'h23: begin ea = xr[ins[19:15]] + imms; dmem[ea[3:2]] = xr[ins[24:20]]; end
                        7'h03: begin ea = xr[ins[19:15]] + immi; xr[ins[11:7]] = dmem[ea[3:2]]; end
                        default: ;
                    endcase
                    xr[0] = 32'h0;
                end
                chk("cpu_x3", xr[3], 30);
                chk("cpu_x4", xr[4], 30);
                chk("cpu_x5", xr[5], 20);
            end
        end
        chk("overwrite_addr0", mem0[0], 32'h04030201);
        chk("untouched_addr2", mem0[2], 32'h002081B3);

        // Overflow on a 4-word IMEM, then recovery.
        for (int i = 0; i < 20; i++) stream[i] = 8'(8'h10 + i);
        start_load(1);
        send(0, 17, 1'b0, 1'b0);
        chk("ovf_writes", wr4, 4);
        chk("ovf_err", err4, 1);
        chk("ovf_in_ready", bus4.in_ready, 0);
        chk("ovf_cpu_rst", cpu_rst4, 1);
        chk("ovf_done", done4, 0);
        chk("ovf_words", wl4, 4);
        chk("ovf_w0", wdat4[0], 32'h13121110);
        chk("ovf_w3", wdat4[3], 32'h1F1E1D1C);
        chk("ovf_a3", wadr4[3], 3);
        v = 1'b1;
        repeat (3) @(negedge clk);
        v = 1'b0;
        chk("ovf_no_more_writes", wr4, 4);
        chk("ovf_err_held", err4, 1);
        for (int i = 0; i < 8; i++) stream[i] = 8'(8'h20 + i);
        start_load(1);
        chk("recover_err_clr", err4, 0);
        send(0, 8, 1'b1, 1'b0);
        k = 0;
        while (!done4 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("recover_done", done4, 1);
        chk("recover_err", err4, 0);
        chk("recover_writes", wr4, 2);
        chk("recover_w0", wdat4[0], 32'h23222120);
        chk("recover_w1", wdat4[1], 32'h27262524);
        chk("recover_a1", wadr4[1], 1);
        chk("recover_words", wl4, 2);

        // load_start ignored mid-load, then reset aborts the load.
        for (int i = 0; i < 10; i++) stream[i] = 8'(i + 1);
        start_load(0);
        send(0, 5, 1'b0, 1'b0);
        ls0 = 1'b1;
        @(negedge clk);
        ls0 = 1'b0;
        send(5, 10, 1'b0, 1'b0);
        @(negedge clk);
        chk("ign_writes", wr0, 2);
        chk("ign_w0", wdat0[0], 32'h04030201);
        chk("ign_w1", wdat0[1], 32'h08070605);
        chk("ign_words", wl0, 2);
        rst = 1'b1;
        #1;
        chk("abort_we", bus0.imem_we, 0);
        chk("abort_cpu_rst", cpu_rst0, 1);
        chk("abort_words", wl0, 0);
        @(negedge clk);
        rst = 1'b0;
        v = 1'b1;
        repeat (5) @(negedge clk);
        v = 1'b0;
        chk("abort_no_writes", wr0, 2);
        chk("abort_in_ready", bus0.in_ready, 0);
        chk("abort_cpu_rst_held", cpu_rst0, 1);
        chk("abort_words_held", wl0, 0);
        chk("abort_done", done0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
